// File: rtl/bfs_csr_if.sv
// CSR request/response bus between a host master and the BFS control slave.
// One request per cycle at most; the response always arrives on the next cycle.
interface bfs_csr_if;
    logic        csr_bfs_valid;
    logic [3:0]  csr_bfs_addr;
    logic        csr_bfs_wen;
    logic [31:0] csr_bfs_wdata;
    logic        bfs_csr_valid;
    logic        bfs_csr_error;
    logic [31:0] bfs_csr_rdata;

    modport master (
        output csr_bfs_valid, csr_bfs_addr, csr_bfs_wen, csr_bfs_wdata,
        input  bfs_csr_valid, bfs_csr_error, bfs_csr_rdata
    );

    modport slave (
        input  csr_bfs_valid, csr_bfs_addr, csr_bfs_wen, csr_bfs_wdata,
        output bfs_csr_valid, bfs_csr_error, bfs_csr_rdata
    );
endinterface

// File: rtl/bfs_csr_slave.sv
// CSR slave that holds BFS job parameters and sequences an engine run.
// state  | meaning
// IDLE   | no job; parameters writable, start accepted when QSIZE != 0
// LAUNCH | one cycle; bfs_start_o asserted toward the engine
// RUN    | engine working; waits for eng_done_i or an abort
module bfs_csr_slave (
    input  logic            clk,
    input  logic            rst_n,
    bfs_csr_if.slave        csr,
    output logic            bfs_start_o,
    output logic            bfs_abort_o,
    output logic [31:0]     bfs_root_o,
    output logic [31:0]     bfs_targ_o,
    output logic [31:0]     bfs_qbase_o,
    output logic [31:0]     bfs_qsize_o,
    input  logic            eng_done_i,
    input  logic            eng_found_i,
    input  logic [31:0]     eng_result_i
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] root_q, root_d, targ_q, targ_d, qbase_q, qbase_d, qsize_q, qsize_d;
    logic [31:0] result_q, result_d, cycles_q, cycles_d;
    logic        done_q, done_d, found_q, found_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        abort_q, abort_d;

    logic        busy, err, wr_ok, stat_wr, start_acc, abort_acc, clr_done, eng_fin;
    logic [31:0] rd_val;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        rd_val = '0;
        case (csr.csr_bfs_addr)
            4'd0:    rd_val = {29'd0, found_q, done_q, busy};
            4'd1:    rd_val = root_q;
            4'd2:    rd_val = targ_q;
            4'd3:    rd_val = qbase_q;
            4'd4:    rd_val = qsize_q;
            4'd5:    rd_val = result_q;
            4'd6:    rd_val = cycles_q;
            default: rd_val = '0;
        endcase
    end

    // A start bit while busy is only tolerated when the same write also aborts.
    always_comb begin
        err = 1'b0;
        if (csr.csr_bfs_addr > 4'd6) begin
            err = 1'b1;
        end else if (csr.csr_bfs_wen) begin
            if (csr.csr_bfs_addr == 4'd5 || csr.csr_bfs_addr == 4'd6)
                err = 1'b1;
            else if (csr.csr_bfs_addr != 4'd0 && busy)
                err = 1'b1;
            else if (csr.csr_bfs_addr == 4'd0 && csr.csr_bfs_wdata[0])
                err = busy ? !csr.csr_bfs_wdata[2] : (qsize_q == 32'd0);
        end
    end

    assign wr_ok     = csr.csr_bfs_valid && csr.csr_bfs_wen && !err;
    assign stat_wr   = wr_ok && (csr.csr_bfs_addr == 4'd0);
    assign start_acc = stat_wr && csr.csr_bfs_wdata[0] && !busy;
    assign abort_acc = stat_wr && csr.csr_bfs_wdata[2] && busy;
    assign clr_done  = stat_wr && csr.csr_bfs_wdata[1];
    assign eng_fin   = (state_q == S_RUN) && eng_done_i && !abort_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bfs_start_o = 1'b0;
        case (state_q)
            S_IDLE:   if (start_acc) state_d = S_LAUNCH;
            S_LAUNCH: begin
                bfs_start_o = 1'b1;
                state_d     = abort_acc ? S_IDLE : S_RUN;
            end
            S_RUN:    if (abort_acc || eng_done_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        root_d   = root_q;
        targ_d   = targ_q;
        qbase_d  = qbase_q;
        qsize_d  = qsize_q;
        result_d = result_q;
        cycles_d = cycles_q;
        done_d   = done_q;
        found_d  = found_q;
        if (wr_ok) begin
            case (csr.csr_bfs_addr)
                4'd1:    root_d  = csr.csr_bfs_wdata;
                4'd2:    targ_d  = csr.csr_bfs_wdata;
                4'd3:    qbase_d = csr.csr_bfs_wdata;
                4'd4:    qsize_d = csr.csr_bfs_wdata;
                default: ;
            endcase
        end
        if (busy && cycles_q != 32'hFFFF_FFFF)
            cycles_d = cycles_q + 32'd1;
        // Engine completion is applied after clear-done so it wins the same edge.
        if (clr_done)
            done_d = 1'b0;
        if (eng_fin) begin
            done_d   = 1'b1;
            found_d  = eng_found_i;
            result_d = eng_result_i;
        end
        if (abort_acc) begin
            done_d  = 1'b0;
            found_d = 1'b0;
        end
        if (start_acc) begin
            done_d   = 1'b0;
            found_d  = 1'b0;
            result_d = '0;
            cycles_d = '0;
        end
        rsp_valid_d = csr.csr_bfs_valid;
        rsp_error_d = csr.csr_bfs_valid && err;
        rsp_rdata_d = (csr.csr_bfs_valid && !err) ? rd_val : 32'd0;
        abort_d     = abort_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q      <= '0;
            targ_q      <= '0;
            qbase_q     <= '0;
            qsize_q     <= '0;
            result_q    <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            root_q      <= root_d;
            targ_q      <= targ_d;
            qbase_q     <= qbase_d;
            qsize_q     <= qsize_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            found_q     <= found_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            abort_q     <= abort_d;
        end
    end

    assign csr.bfs_csr_valid = rsp_valid_q;
    assign csr.bfs_csr_error = rsp_error_q;
    assign csr.bfs_csr_rdata = rsp_rdata_q;
    assign bfs_abort_o       = abort_q;
    assign bfs_root_o        = root_q;
    assign bfs_targ_o        = targ_q;
    assign bfs_qbase_o       = qbase_q;
    assign bfs_qsize_o       = qsize_q;

endmodule

// File: tb/tb_bfs_csr_slave.sv
// Bench for bfs_csr_slave: directed job scenarios then random CSR/engine traffic,
// every cycle compared against a register-map level model of the block.
module tb_bfs_csr_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bfs_start, bfs_abort;
    logic [31:0] bfs_root, bfs_targ, bfs_qbase, bfs_qsize;
    logic        eng_done = 1'b0, eng_found = 1'b0;
    logic [31:0] eng_result = '0;

    bfs_csr_if csr_if ();

    bfs_csr_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr          (csr_if.slave),
        .bfs_start_o  (bfs_start),
        .bfs_abort_o  (bfs_abort),
        .bfs_root_o   (bfs_root),
        .bfs_targ_o   (bfs_targ),
        .bfs_qbase_o  (bfs_qbase),
        .bfs_qsize_o  (bfs_qsize),
        .eng_done_i   (eng_done),
        .eng_found_i  (eng_found),
        .eng_result_i (eng_result)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: job phase 0=no job, 1=launch cycle, 2=engine running.
    int          m_phase;
    logic [31:0] m_par [0:3];
    logic [31:0] m_result, m_cycles;
    logic        m_done, m_found;
    logic        e_valid, e_err, e_start, e_abort;
    logic [31:0] e_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        for (int i = 0; i < 4; i++) m_par[i] = '0;
        m_result = '0; m_cycles = '0; m_done = 1'b0; m_found = 1'b0;
        e_valid = 1'b0; e_err = 1'b0; e_rdata = '0; e_start = 1'b0; e_abort = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return {29'd0, m_found, m_done, (m_phase != 0)};
            4'd1, 4'd2, 4'd3, 4'd4: return m_par[int'(a) - 1];
            4'd5: return m_result;
            4'd6: return m_cycles;
            default: return '0;
        endcase
    endfunction

    function automatic void model_step(input logic v, input logic w, input logic [3:0] a,
                                       input logic [31:0] d, input logic ed, input logic ef,
                                       input logic [31:0] er);
        logic busy, err, ok_wr, start_ok, abort_ok;
        int   old;
        busy = (m_phase != 0);
        err  = 1'b0;
        if (v) begin
            if (a >= 4'd7) err = 1'b1;
            else if (w) begin
                if (a == 4'd5 || a == 4'd6) err = 1'b1;
                else if (a != 4'd0 && busy) err = 1'b1;
                else if (a == 4'd0 && d[0]) err = busy ? !d[2] : (m_par[3] == 32'd0);
            end
        end
        e_valid  = v;
        e_err    = v && err;
        e_rdata  = (v && !err) ? m_read(a) : 32'd0;
        ok_wr    = v && w && !err;
        start_ok = ok_wr && a == 4'd0 && d[0] && !busy;
        abort_ok = ok_wr && a == 4'd0 && d[2] && busy;
        old = m_phase;
        if (old != 0 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (old == 1) m_phase = 2;
        if (ok_wr && a >= 4'd1 && a <= 4'd4) m_par[int'(a) - 1] = d;
        if (ok_wr && a == 4'd0 && d[1]) m_done = 1'b0;
        if (old == 2 && ed && !abort_ok) begin
            m_done = 1'b1; m_found = ef; m_result = er; m_phase = 0;
        end
        if (abort_ok) begin
            m_phase = 0; m_done = 1'b0; m_found = 1'b0;
        end
        if (start_ok) begin
            m_phase = 1; m_done = 1'b0; m_found = 1'b0; m_result = '0; m_cycles = '0;
        end
        e_abort = abort_ok;
        e_start = (m_phase == 1);
    endfunction

    task automatic step(input logic v, input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic ed = 1'b0, input logic ef = 1'b0, input logic [31:0] er = '0);
        csr_if.csr_bfs_valid = v;
        csr_if.csr_bfs_wen   = w;
        csr_if.csr_bfs_addr  = a;
        csr_if.csr_bfs_wdata = d;
        eng_done   = ed;
        eng_found  = ef;
        eng_result = er;
        model_step(v, w, a, d, ed, ef, er);
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(csr_if.bfs_csr_valid), 32'(e_valid));
        chk("rsp_error", 32'(csr_if.bfs_csr_error), 32'(e_err));
        chk("rsp_rdata", csr_if.bfs_csr_rdata, e_rdata);
        chk("bfs_start", 32'(bfs_start), 32'(e_start));
        chk("bfs_abort", 32'(bfs_abort), 32'(e_abort));
        chk("bfs_root", bfs_root, m_par[0]);
        chk("bfs_targ", bfs_targ, m_par[1]);
        chk("bfs_qbase", bfs_qbase, m_par[2]);
        chk("bfs_qsize", bfs_qsize, m_par[3]);
        csr_if.csr_bfs_valid = 1'b0;
        csr_if.csr_bfs_wen   = 1'b0;
        eng_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(csr_if.bfs_csr_valid), 32'd0);
        chk({tag, "_error"}, 32'(csr_if.bfs_csr_error), 32'd0);
        chk({tag, "_rdata"}, csr_if.bfs_csr_rdata, 32'd0);
        chk({tag, "_start"}, 32'(bfs_start), 32'd0);
        chk({tag, "_abort"}, 32'(bfs_abort), 32'd0);
        chk({tag, "_params"}, bfs_root | bfs_targ | bfs_qbase | bfs_qsize, 32'd0);
    endtask

    initial begin
        logic        rv, rw, red, ref_;
        logic [3:0]  ra;
        logic [31:0] rd, rer;
        csr_if.csr_bfs_valid = 1'b0;
        csr_if.csr_bfs_wen   = 1'b0;
        csr_if.csr_bfs_addr  = '0;
        csr_if.csr_bfs_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Parameter write/readback.
        step(1, 1, 4'd1, 32'h10);
        chk("wr_root_err", 32'(csr_if.bfs_csr_error), 32'd0);
        step(1, 1, 4'd2, 32'h20);
        step(1, 1, 4'd4, 32'h100);
        step(1, 0, 4'd1, 32'd0);
        chk("rd_root", csr_if.bfs_csr_rdata, 32'h10);
        step(1, 0, 4'd2, 32'd0);
        chk("rd_targ", csr_if.bfs_csr_rdata, 32'h20);
        step(1, 0, 4'd4, 32'd0);
        chk("rd_qsize", csr_if.bfs_csr_rdata, 32'h100);

        // Launch, busy-time rejections, completion after 10 RUN cycles.
        step(1, 1, 4'd0, 32'h1);
        chk("start_pulse", 32'(bfs_start), 32'd1);
        step(1, 0, 4'd0, 32'd0);
        chk("stat_busy", csr_if.bfs_csr_rdata, 32'h1);
        chk("start_gone", 32'(bfs_start), 32'd0);
        step(1, 1, 4'd1, 32'hDEAD);
        chk("busy_wr_err", 32'(csr_if.bfs_csr_error), 32'd1);
        step(1, 1, 4'd0, 32'h1);
        chk("busy_start_err", 32'(csr_if.bfs_csr_error), 32'd1);
        step(1, 0, 4'd9, 32'd0);
        chk("addr9_err", 32'(csr_if.bfs_csr_error), 32'd1);
        chk("addr9_rdata", csr_if.bfs_csr_rdata, 32'd0);
        step(1, 0, 4'd1, 32'd0);
        chk("root_kept", csr_if.bfs_csr_rdata, 32'h10);
        idle(5);
        step(0, 0, 4'd0, 32'd0, 1'b1, 1'b1, 32'd7);
        step(1, 0, 4'd0, 32'd0);
        chk("stat_done", csr_if.bfs_csr_rdata, 32'h6);
        step(1, 0, 4'd5, 32'd0);
        chk("result", csr_if.bfs_csr_rdata, 32'd7);
        step(1, 0, 4'd6, 32'd0);
        chk("cycles", csr_if.bfs_csr_rdata, 32'd11);

        // Zero queue size rejects start; later abort during RUN.
        step(1, 1, 4'd4, 32'd0);
        step(1, 1, 4'd0, 32'h1);
        chk("qsize0_err", 32'(csr_if.bfs_csr_error), 32'd1);
        chk("qsize0_nostart", 32'(bfs_start), 32'd0);
        step(1, 1, 4'd4, 32'h40);
        step(1, 1, 4'd0, 32'h1);
        idle(2);
        step(1, 1, 4'd0, 32'h4);
        chk("abort_pulse", 32'(bfs_abort), 32'd1);
        step(1, 0, 4'd0, 32'd0);
        chk("abort_once", 32'(bfs_abort), 32'd0);
        chk("stat_after_abort", csr_if.bfs_csr_rdata, 32'h0);

        // Clear-done racing engine completion: completion wins.
        step(1, 1, 4'd0, 32'h1);
        idle(3);
        step(1, 1, 4'd0, 32'h2, 1'b1, 1'b0, 32'd3);
        step(1, 0, 4'd0, 32'd0);
        chk("done_wins", csr_if.bfs_csr_rdata, 32'h2);
        // Start+abort while idle: start wins.
        step(1, 1, 4'd0, 32'h5);
        chk("start_abort_idle", 32'(bfs_start), 32'd1);
        chk("no_abort_idle", 32'(bfs_abort), 32'd0);
        // Start+abort while busy: abort, no error.
        step(1, 1, 4'd0, 32'h5);
        chk("start_abort_busy_err", 32'(csr_if.bfs_csr_error), 32'd0);
        chk("start_abort_busy_ab", 32'(bfs_abort), 32'd1);

        // Reset mid-RUN.
        step(1, 1, 4'd0, 32'h1);
        idle(3);
        step(1, 0, 4'd0, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 4'd0, 32'd0);
        chk("stat_after_rst", csr_if.bfs_csr_rdata, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rw  = $urandom_range(0, 1) == 1;
            ra  = 4'($urandom_range(0, 10));
            if (ra > 4'd8) ra = 4'd0;
            if (ra == 4'd0) rd = 32'($urandom_range(0, 7));
            else if ($urandom_range(0, 5) == 0) rd = 32'd0;
            else rd = $urandom;
            red  = ($urandom_range(0, 11) == 0);
            ref_ = $urandom_range(0, 1) == 1;
            rer  = $urandom;
            step(rv, rw, ra, rd, red, ref_, rer);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
